// File: rtl/idct_8x8.sv
// 8x8 inverse DCT: 64 coefficients in, row pass, column pass, 64 pixels out, one shared MAC.
// Define IDCT_LEVEL_SHIFT_EN to add 128 to every reconstructed sample before clamping.
module idct_8x8 #(
  parameter int COEF_W = 16,
  parameter int FRAC   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_pixel,
  output logic              out_last,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both 1;
  // valid never drops and data never changes until that transfer has happened.

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic signed [31:0] HALF = 32'sd1 <<< (FRAC - 1);
  localparam logic signed [31:0] SMAX = (32'sd1 <<< (COEF_W - 1)) - 32'sd1;
  localparam logic signed [31:0] SMIN = -(32'sd1 <<< (COEF_W - 1));
`ifdef IDCT_LEVEL_SHIFT_EN
  localparam logic signed [31:0] LVL_OFS = 32'sd128;
`else
  localparam logic signed [31:0] LVL_OFS = 32'sd0;
`endif

  // Basis entry C[k][n]; the angle is folded into the first quadrant so only the
  // seven distinct magnitudes (kept as Q30 constants) are needed, then rounded to FRAC bits.
  function automatic logic signed [15:0] cos_coef(input int k, input int n);
    int     m;
    logic   neg;
    longint q;
    m   = ((2 * n + 1) * k) % 32;
    neg = 1'b0;
    if (m > 16) m = 32 - m;
    if (m > 8) begin
      m   = 16 - m;
      neg = 1'b1;
    end
    case (m)
      0:       q = 64'sd536870912;
      1:       q = 64'sd526555088;
      2:       q = 64'sd496004047;
      3:       q = 64'sd446391858;
      4:       q = 64'sd379625062;
      5:       q = 64'sd298269498;
      6:       q = 64'sd205451603;
      7:       q = 64'sd104738319;
      default: q = 64'sd0;
    endcase
    if (k == 0) q = 64'sd379625062;
    q = (q + (64'sd1 <<< (29 - FRAC))) >>> (30 - FRAC);
    return neg ? -16'(q) : 16'(q);
  endfunction

  logic signed [15:0] ctab [64];

  for (genvar g = 0; g < 64; g++) begin : g_ctab
    assign ctab[g] = cos_coef(g / 8, g % 8);
  end

  state_t                    state;
  logic [5:0]                in_cnt;
  logic [5:0]                e_cnt;
  logic [3:0]                k_cnt;
  logic [5:0]                out_cnt;
  logic signed [31:0]        acc;

  logic [COEF_W-1:0]         coef_mem [64];
  logic [COEF_W-1:0]         t_mem [64];
  logic [7:0]                pix_mem [64];

  logic signed [COEF_W-1:0]  mac_a;
  logic signed [15:0]        mac_c;
  logic signed [COEF_W+15:0] prod;
  logic signed [31:0]        rnd;
  logic signed [31:0]        lvl;
  logic [COEF_W-1:0]         t_wr;
  logic [7:0]                pix_wr;

  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign dbg_state = state;

  // ROW walks e = v*8+x over u = k; COL walks e = y*8+x over v = k.
  always_comb begin
    mac_a = $signed(coef_mem[{e_cnt[5:3], k_cnt[2:0]}]);
    mac_c = ctab[{k_cnt[2:0], e_cnt[2:0]}];
    if (state == COL) begin
      mac_a = $signed(t_mem[{k_cnt[2:0], e_cnt[2:0]}]);
      mac_c = ctab[{k_cnt[2:0], e_cnt[5:3]}];
    end
  end

  assign prod = mac_a * mac_c;
  assign rnd  = (acc + HALF) >>> FRAC;
  assign lvl  = rnd + LVL_OFS;

  always_comb begin
    t_wr = rnd[COEF_W-1:0];
    if (rnd > SMAX) t_wr = SMAX[COEF_W-1:0];
    else if (rnd < SMIN) t_wr = SMIN[COEF_W-1:0];
    pix_wr = lvl[7:0];
    if (lvl < 32'sd0) pix_wr = 8'd0;
    else if (lvl > 32'sd255) pix_wr = 8'd255;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      in_cnt    <= 6'd0;
      e_cnt     <= 6'd0;
      k_cnt     <= 4'd0;
      out_cnt   <= 6'd0;
      acc       <= 32'sd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_pixel <= 8'd0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            in_cnt <= in_cnt + 6'd1;
            if (in_cnt == 6'd63) begin
              state <= ROW;
              e_cnt <= 6'd0;
              k_cnt <= 4'd0;
              acc   <= 32'sd0;
            end
          end
        end
        ROW, COL: begin
          // Eight MAC steps, then one step that writes the result and clears the accumulator.
          if (k_cnt == 4'd8) begin
            acc   <= 32'sd0;
            k_cnt <= 4'd0;
            e_cnt <= e_cnt + 6'd1;
            if (e_cnt == 6'd63) state <= (state == ROW) ? COL : OUT;
          end else begin
            acc   <= acc + 32'(prod);
            k_cnt <= k_cnt + 4'd1;
          end
        end
        OUT: begin
          // The first OUT cycle only loads the output register from the pixel store.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_pixel <= pix_mem[out_cnt];
            out_last  <= (out_cnt == 6'd63);
          end else if (out_ready) begin
            if (out_cnt == 6'd63) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_cnt   <= 6'd0;
            end else begin
              out_cnt   <= out_cnt + 6'd1;
              out_pixel <= pix_mem[out_cnt + 6'd1];
              out_last  <= ((out_cnt + 6'd1) == 6'd63);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Storage arrays carry no reset: each is fully rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) coef_mem[in_cnt] <= in_coef;
    if (state == ROW && k_cnt == 4'd8) t_mem[e_cnt] <= t_wr;
    if (state == COL && k_cnt == 4'd8) pix_mem[e_cnt] <= pix_wr;
  end

endmodule

// File: doc/idct_8x8.md
IDCT_8X8 -- requirements
Module: idct_8x8

Interface
REQ-001 Parameter COEF_W, default 16, is the signed coefficient and intermediate width.
REQ-002 Parameter FRAC, default 8, is the number of fractional bits of the internal cosine table.
REQ-003 Port clk, input, 1 bit, is the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, is an asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit, marks that in_coef is valid.
REQ-006 Port in_ready, output, 1 bit, shows that the block accepts a coefficient.
REQ-007 Port in_coef, input, COEF_W bits, carries the signed DCT coefficient.
REQ-008 Port out_valid, output, 1 bit, marks that out_pixel is valid.
REQ-009 Port out_ready, input, 1 bit, shows that the sink accepts a pixel.
REQ-010 Port out_pixel, output, 8 bits, carries the unsigned reconstructed pixel.
REQ-011 Port out_last, output, 1 bit, is high with the 64th pixel of a block.
REQ-012 Port busy, output, 1 bit, is high in every state except LOAD.

Function
REQ-013 The block SHALL be the inverse of the team's 2D 8x8 DCT, using the same orthonormal basis.
REQ-014 The block SHALL hold an internal 8x8 table C[k][n] = round(2^FRAC * c(k) * cos((2n+1)k*pi/16)), where c(0) = sqrt(1/8) and c(k>0) = 1/2, so C[0][n] = 91.
REQ-015 The state machine SHALL have states LOAD, ROW, COL and OUT, in a fixed cycle LOAD->ROW->COL->OUT->LOAD.
REQ-016 In LOAD, in_ready SHALL be 1, and a beat SHALL transfer when in_valid and in_ready are both 1.
REQ-017 Coefficients SHALL arrive in row-major order; beat i is F[v=i/8][u=i%8].
REQ-018 On the 64th accepted beat, the block SHALL move to ROW on the next edge, and in_ready SHALL be 0 from that edge.
REQ-019 ROW SHALL compute T[v][x] = sat_COEF_W((sum_u C[u][x]*F[v][u] + 2^(FRAC-1)) >>> FRAC).
REQ-020 ROW SHALL use one MAC with a 32-bit signed accumulator, taking 8 MAC cycles plus 1 write cycle per element.
REQ-021 ROW SHALL take exactly 576 cycles.
REQ-022 COL SHALL compute P[y][x] = (sum_v C[v][y]*T[v][x] + 2^(FRAC-1)) >>> FRAC, with the same timing as ROW (576 cycles).
REQ-023 The stored pixel SHALL be P after the post-process of REQ-034/REQ-035, clamped to 0..255.
REQ-024 The first out_valid SHALL occur exactly 1153 clk edges after the edge that accepts the 64th coefficient.
REQ-025 OUT SHALL emit 64 pixels in row-major order [y][x].
REQ-026 out_pixel and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 No beat SHALL be lost or duplicated under backpressure.
REQ-028 out_valid SHALL never deassert before its beat has transferred.
REQ-029 After the 64th pixel transfers, the next edge SHALL give out_valid=0 and in_ready=1 (LOAD).
REQ-030 Input beats presented while in_ready=0 SHALL be ignored, with no effect on state.
REQ-031 The coefficient counter and the output counter SHALL each wrap from 63 to 0 at block boundaries.

Reset
REQ-032 While rst_n=0, regardless of clk, the block SHALL force state=LOAD, all counters and the accumulator to 0, in_ready=1, out_valid=0, out_last=0, busy=0 and out_pixel=0.
REQ-033 A reset during any state SHALL discard the partial block; the first beat after release SHALL be F[0][0] of a new block.

Configuration
REQ-034 With macro IDCT_LEVEL_SHIFT_EN defined, 128 SHALL be added to P before clamping, so all-zero coefficients give pixels of 128.
REQ-035 Without IDCT_LEVEL_SHIFT_EN, P SHALL be clamped directly, so all-zero coefficients give pixels of 0; no other behaviour or timing SHALL change.

Verification
REQ-036 Reset check: hold rst_n=0 mid-clock -> in_ready=1, out_valid=0 and busy=0 immediately, with no clock edge needed.
REQ-037 DC-only block: F[0][0]=64, all other coefficients 0, shift enabled -> all 64 pixels = 136, and out_last only on beat 64.
REQ-038 Zero block: all coefficients 0 -> all pixels 128 with the macro, 0 without it.
REQ-039 Clamp block: F[0][0]=2047, rest 0 -> all pixels 255; F[0][0]=-2048, rest 0 -> all pixels 0 (shift enabled).
REQ-040 Timing and backpressure: out_ready=1 except held 0 for 10 cycles at beat 5 -> first out_valid 1153 edges after the last input accept, beat 5 held stable, exactly 64 beats emitted, and in_ready=1 one edge after the final transfer.
REQ-041 Mid-operation reset: assert rst_n 300 cycles into COL, then send the DC-only block -> outputs match REQ-037 exactly, with no stale pixels.
